// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: request/response channels of both clients plus the shared ALU port.
interface alu_share_arbiter_if #(parameter int N = 4);
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [N-1:0] req_a0;
    logic [N-1:0] req_b0;
    logic [N-1:0] req_a1;
    logic [N-1:0] req_b1;
    logic [1:0]   req_op0;
    logic [1:0]   req_op1;
    logic [1:0]   rsp_valid;
    logic [1:0]   rsp_ready;
    logic [N-1:0] rsp_out;
    logic         rsp_cout;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [1:0]   alu_ctrl;
    logic [N-1:0] alu_out;
    logic         alu_cout;
    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1, rsp_ready, alu_out, alu_cout,
        input  req_ready, rsp_valid, rsp_out, rsp_cout, alu_a, alu_b, alu_ctrl
    );
    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1, rsp_ready, alu_out, alu_cout,
        output req_ready, rsp_valid, rsp_out, rsp_cout, alu_a, alu_b, alu_ctrl
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one flag-less ALU between two requesters.
module alu_share_arbiter #(
    parameter int N = 4
) (
    input  logic                clk,
    input  logic                rst,
    alu_share_arbiter_if.slave  bus_io,
    output logic                busy_o,
    output logic                grant_id_o
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t       state_q, state_d;
    logic         ptr_q, ptr_d;
    logic         gid_q, gid_d;
    logic [N-1:0] opa_q, opa_d;
    logic [N-1:0] opb_q, opb_d;
    logic [N-1:0] res_q, res_d;
    logic [1:0]   opc_q, opc_d;
    logic         cr_q, cr_d;
    logic         any_req, win, accept, rsp_done;
    assign any_req  = |bus_io.req_valid;
    // the pointer only breaks ties; a lone request always wins
    assign win      = &bus_io.req_valid ? ptr_q : bus_io.req_valid[1];
    assign accept   = (state_q == IDLE) && any_req;
    assign rsp_done = (state_q == RESP) && bus_io.rsp_ready[gid_q];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        if (accept)                state_d = EXEC;
        else if (state_q == EXEC)  state_d = RESP;
        else if (rsp_done)         state_d = IDLE;
    end
    always_comb begin
        bus_io.req_ready = accept ? (win ? 2'b10 : 2'b01) : 2'b00;
        bus_io.rsp_valid = (state_q == RESP) ? (gid_q ? 2'b10 : 2'b01) : 2'b00;
        bus_io.rsp_out   = res_q;
        bus_io.rsp_cout  = cr_q;
        bus_io.alu_a     = opa_q;
        bus_io.alu_b     = opb_q;
        bus_io.alu_ctrl  = opc_q;
        busy_o           = state_q != IDLE;
        grant_id_o       = gid_q;
    end
    always_comb begin
        ptr_d = rsp_done ? ~gid_q : ptr_q;
        gid_d = accept ? win : gid_q;
        opa_d = accept ? (win ? bus_io.req_a1 : bus_io.req_a0) : opa_q;
        opb_d = accept ? (win ? bus_io.req_b1 : bus_io.req_b0) : opb_q;
        opc_d = accept ? (win ? bus_io.req_op1 : bus_io.req_op0) : opc_q;
        res_d = (state_q == EXEC) ? bus_io.alu_out : res_q;
        // XOR/NOT carry is meaningless from a flag-less ALU, so it is masked
        cr_d  = (state_q == EXEC) ? (bus_io.alu_cout & ~opc_q[1]) : cr_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
            gid_q <= 1'b0;
            opa_q <= '0;
            opb_q <= '0;
            opc_q <= 2'b00;
            res_q <= '0;
            cr_q  <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            gid_q <= gid_d;
            opa_q <= opa_d;
            opb_q <= opb_d;
            opc_q <= opc_d;
            res_q <= res_d;
            cr_q  <= cr_d;
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed vectors against a behavioural 4-bit ALU.
module tb_alu_share_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, gid;
    logic force_cout = 1'b0;
    logic [4:0] sum;
    int n_vec = 0;
    int n_err = 0;
    alu_share_arbiter_if #(.N(4)) bus ();
    alu_share_arbiter #(.N(4)) dut (.clk(clk), .rst(rst), .bus_io(bus), .busy_o(busy), .grant_id_o(gid));
    always #5 clk = ~clk;
    always_comb begin
        sum = bus.alu_ctrl[0] ? ({1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 5'd1)
                              : ({1'b0, bus.alu_a} + {1'b0, bus.alu_b});
        bus.alu_out  = (bus.alu_ctrl == 2'b10) ? (bus.alu_a ^ bus.alu_b) :
                       (bus.alu_ctrl == 2'b11) ? ~bus.alu_b : sum[3:0];
        bus.alu_cout = bus.alu_ctrl[1] ? force_cout : sum[4];
    end
    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic chk_reset(input string tag);
        chk({tag, " busy"}, 8'(busy), 8'd0);
        chk({tag, " gid"}, 8'(gid), 8'd0);
        chk({tag, " req_ready"}, 8'(bus.req_ready), 8'd0);
        chk({tag, " rsp_valid"}, 8'(bus.rsp_valid), 8'd0);
        chk({tag, " rsp_out"}, 8'(bus.rsp_out), 8'd0);
        chk({tag, " rsp_cout"}, 8'(bus.rsp_cout), 8'd0);
        chk({tag, " alu_a"}, 8'(bus.alu_a), 8'd0);
        chk({tag, " alu_b"}, 8'(bus.alu_b), 8'd0);
        chk({tag, " alu_ctrl"}, 8'(bus.alu_ctrl), 8'd0);
    endtask
    task automatic release_rst();
        @(negedge clk) rst = 1'b0;
        @(posedge clk) #1;
    endtask
    task automatic set_req(input int r, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        if (r == 0) begin
            bus.req_op0 = op; bus.req_a0 = a; bus.req_b0 = b;
        end else begin
            bus.req_op1 = op; bus.req_a1 = a; bus.req_b1 = b;
        end
    endtask
    // entered #1 after an edge with the FSM in IDLE; leaves it back in IDLE
    task automatic run_op(input string tag, input logic [1:0] vld, input logic g,
                          input logic [3:0] eout, input logic ecout, input logic keep);
        bus.req_valid = vld;
        #1 chk({tag, " accept"}, 8'(bus.req_ready), g ? 8'd2 : 8'd1);
        @(posedge clk) #1;
        if (!keep) bus.req_valid = 2'b00;
        chk({tag, " exec busy"}, 8'(busy), 8'd1);
        chk({tag, " grant"}, 8'(gid), 8'(g));
        chk({tag, " exec no ready"}, 8'(bus.req_ready), 8'd0);
        chk({tag, " exec no rsp"}, 8'(bus.rsp_valid), 8'd0);
        @(posedge clk) #1;
        chk({tag, " rsp_valid"}, 8'(bus.rsp_valid), g ? 8'd2 : 8'd1);
        chk({tag, " rsp_out"}, 8'(bus.rsp_out), 8'(eout));
        chk({tag, " rsp_cout"}, 8'(bus.rsp_cout), 8'(ecout));
        @(posedge clk) #1;
        chk({tag, " idle rsp"}, 8'(bus.rsp_valid), 8'd0);
        chk({tag, " idle busy"}, 8'(busy), 8'd0);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b11;
        set_req(0, 2'b00, 4'd0, 4'd0);
        set_req(1, 2'b00, 4'd0, 4'd0);
        #1 chk_reset("por");
        release_rst();
        set_req(0, 2'b00, 4'd7, 4'd9);
        run_op("add7+9", 2'b01, 1'b0, 4'd0, 1'b1, 1'b0);
        set_req(1, 2'b01, 4'd3, 4'd5);
        run_op("sub3-5", 2'b10, 1'b1, 4'd14, 1'b0, 1'b0);
        set_req(1, 2'b01, 4'd5, 4'd3);
        run_op("sub5-3", 2'b10, 1'b1, 4'd2, 1'b1, 1'b0);
        force_cout = 1'b1;
        set_req(0, 2'b10, 4'b1010, 4'b0110);
        run_op("xor", 2'b01, 1'b0, 4'b1100, 1'b0, 1'b0);
        set_req(0, 2'b11, 4'b0000, 4'b0011);
        run_op("not", 2'b01, 1'b0, 4'b1100, 1'b0, 1'b0);
        force_cout = 1'b0;
        rst = 1'b1;
        #1 chk_reset("rst idle");
        release_rst();
        set_req(0, 2'b00, 4'd1, 4'd2);
        set_req(1, 2'b00, 4'd4, 4'd4);
        for (int i = 0; i < 6; i++)
            run_op($sformatf("rr%0d", i), 2'b11, 1'(i % 2), (i % 2) ? 4'd8 : 4'd3, 1'b0, 1'b1);
        bus.req_valid = 2'b00;
        set_req(0, 2'b01, 4'd9, 4'd2);
        set_req(1, 2'b10, 4'b1111, 4'b0101);
        bus.rsp_ready = 2'b10;
        bus.req_valid = 2'b01;
        #1 chk("stall accept", 8'(bus.req_ready), 8'd1);
        @(posedge clk) #1;
        bus.req_valid = 2'b10;
        chk("stall exec ready", 8'(bus.req_ready), 8'd0);
        @(posedge clk) #1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall%0d rsp_valid", i), 8'(bus.rsp_valid), 8'd1);
            chk($sformatf("stall%0d rsp_out", i), 8'(bus.rsp_out), 8'd7);
            chk($sformatf("stall%0d rsp_cout", i), 8'(bus.rsp_cout), 8'd1);
            chk($sformatf("stall%0d ready", i), 8'(bus.req_ready), 8'd0);
            @(posedge clk) #1;
        end
        bus.rsp_ready = 2'b11;
        #1 chk("stall release rsp", 8'(bus.rsp_valid), 8'd1);
        @(posedge clk) #1;
        run_op("after stall", 2'b10, 1'b1, 4'b1010, 1'b0, 1'b0);
        set_req(0, 2'b00, 4'd1, 4'd1);
        run_op("ptr to 1", 2'b01, 1'b0, 4'd2, 1'b0, 1'b0);
        set_req(1, 2'b01, 4'd8, 4'd1);
        bus.req_valid = 2'b10;
        @(posedge clk) #1;
        bus.req_valid = 2'b00;
        chk("pre-rst exec busy", 8'(busy), 8'd1);
        rst = 1'b1;
        #1 chk_reset("rst exec");
        release_rst();
        set_req(0, 2'b00, 4'd2, 4'd3);
        set_req(1, 2'b00, 4'd6, 4'd6);
        run_op("post exec rst", 2'b11, 1'b0, 4'd5, 1'b0, 1'b0);
        set_req(1, 2'b01, 4'd8, 4'd1);
        bus.req_valid = 2'b10;
        @(posedge clk) #1;
        bus.req_valid = 2'b00;
        @(posedge clk) #1;
        chk("pre-rst resp valid", 8'(bus.rsp_valid), 8'd2);
        rst = 1'b1;
        #1 chk_reset("rst resp");
        release_rst();
        run_op("post resp rst", 2'b11, 1'b0, 4'd5, 1'b0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
